// File: rtl/dma_port_arbiter_if.sv
// dma_port_arbiter_if: requester-side and DMA-side signals of the shared DMA port.
// The master side drives requests and dmaDone; the slave side is the arbiter.
interface dma_port_arbiter_if #(
    parameter int DATA_SIZE = 16,
    parameter int N_REQ = 3
);
    logic enable;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] reqWrite;
    logic [N_REQ*DATA_SIZE-1:0] reqAddr;
    logic [N_REQ*DATA_SIZE-1:0] reqData;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] reqDone;
    logic reqError;
    logic dmaEnable;
    logic dmaWrite;
    logic [DATA_SIZE-1:0] dmaAddress;
    logic [DATA_SIZE-1:0] dmaInput;
    logic dmaDone;
    logic busy;

    modport master (
        output enable, req, reqWrite, reqAddr, reqData, dmaDone,
        input grant, reqDone, reqError, dmaEnable, dmaWrite, dmaAddress, dmaInput, busy
    );

    modport slave (
        input enable, req, reqWrite, reqAddr, reqData, dmaDone,
        output grant, reqDone, reqError, dmaEnable, dmaWrite, dmaAddress, dmaInput, busy
    );
endinterface

// File: rtl/dma_port_arbiter.sv
// dma_port_arbiter: round-robin arbiter sharing one DMA port among N_REQ requesters,
// with a per-access timeout and a one-cycle RELEASE gap between owners.
module dma_port_arbiter #(
    parameter int DATA_SIZE = 16,
    parameter int N_REQ = 3,
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic reset,
    dma_port_arbiter_if.slave bus
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t state, nextState;
    logic [IW-1:0] lastGrant, pick, idx;
    logic [CW-1:0] timer;
    logic found, start, done, expire;

    // first asserted requester after lastGrant, wrapping modulo N_REQ
    always_comb begin
        found = 1'b0;
        pick = lastGrant;
        idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IW'((int'(lastGrant) + k) % N_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick = idx;
            end
        end
    end

    always_comb begin
        start = state == IDLE && bus.enable && found;
        done = state == BUSY && bus.dmaDone;
        expire = state == BUSY && !bus.dmaDone && timer == CW'(TIMEOUT - 1);
        nextState = start ? BUSY : (done || expire) ? RELEASE : state == RELEASE ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lastGrant <= IW'(N_REQ - 1);
            timer <= '0;
            bus.grant <= '0;
            bus.reqDone <= '0;
            bus.reqError <= 1'b0;
            bus.dmaEnable <= 1'b0;
            bus.dmaWrite <= 1'b0;
            bus.dmaAddress <= '0;
            bus.dmaInput <= '0;
            bus.busy <= 1'b0;
        end else begin
            state <= nextState;
            bus.busy <= nextState != IDLE;
            bus.reqDone <= '0;
            bus.reqError <= 1'b0;
            if (start) begin
                bus.grant <= N_REQ'(1) << pick;
                bus.dmaEnable <= 1'b1;
                bus.dmaWrite <= bus.reqWrite[pick];
                bus.dmaAddress <= bus.reqAddr[pick*DATA_SIZE +: DATA_SIZE];
                bus.dmaInput <= bus.reqData[pick*DATA_SIZE +: DATA_SIZE];
                lastGrant <= pick;
                timer <= '0;
            end else if (done || expire) begin
                // dmaDone outranks a coincident timeout, so reqError only on a pure expiry
                bus.grant <= '0;
                bus.dmaEnable <= 1'b0;
                bus.reqDone <= bus.grant;
                bus.reqError <= expire;
            end else if (state == BUSY) begin
                timer <= timer + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_dma_port_arbiter.sv
// tb_dma_port_arbiter: directed vector table for the main arbitration trace plus
// hand-written timeout and reset-mid-access sequences (TIMEOUT = 8).
module tb_dma_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int nVec = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    dma_port_arbiter_if #(.DATA_SIZE(16), .N_REQ(3)) bus();
    dma_port_arbiter #(.DATA_SIZE(16), .N_REQ(3), .TIMEOUT(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic rst, en;
        logic [2:0] req, wr;
        logic [47:0] addr, data;
        logic done;
        logic [2:0] grant, rdone;
        logic err, dEn, dWr;
        logic [15:0] dAddr, dIn;
        logic busy;
    } vec_t;

    localparam logic [47:0] A = {16'h0300, 16'h0200, 16'h0100};
    localparam logic [47:0] D = {16'h3333, 16'h2222, 16'h1111};
    localparam logic [47:0] A38 = {16'h0040, 16'h0200, 16'h0100};
    localparam logic [47:0] D38 = {16'h1234, 16'h2222, 16'h1111};
    localparam logic [47:0] AX = 48'hFFFF_FFFF_FFFF;

    vec_t tbl[30];

    function automatic vec_t mk(logic rst, logic en, logic [2:0] req, logic [2:0] wr,
                                logic [47:0] addr, logic [47:0] data, logic done,
                                logic [2:0] grant, logic [2:0] rdone, logic err, logic dEn,
                                logic dWr, logic [15:0] dAddr, logic [15:0] dIn, logic busy);
        vec_t v;
        v.rst = rst; v.en = en; v.req = req; v.wr = wr; v.addr = addr; v.data = data;
        v.done = done; v.grant = grant; v.rdone = rdone; v.err = err; v.dEn = dEn;
        v.dWr = dWr; v.dAddr = dAddr; v.dIn = dIn; v.busy = busy;
        return v;
    endfunction

    task automatic drive(logic rst, logic en, logic [2:0] req, logic [2:0] wr,
                         logic [47:0] addr, logic [47:0] data, logic done);
        reset = rst;
        bus.enable = en;
        bus.req = req;
        bus.reqWrite = wr;
        bus.reqAddr = addr;
        bus.reqData = data;
        bus.dmaDone = done;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {22'd0, bus.grant, bus.reqDone, bus.reqError, bus.dmaEnable, bus.dmaWrite,
                bus.dmaAddress, bus.dmaInput, bus.busy};
    endfunction

    function automatic logic [63:0] hs();
        return {56'd0, bus.grant, bus.reqDone, bus.reqError, bus.busy};
    endfunction

    initial begin
        // round-robin 001,010,100,001 with a RELEASE before each regrant
        tbl[0]  = mk(1, 0, 3'b000, 3'b000, A, D, 0,   3'b000, 3'b000, 0, 0, 0, 16'h0000, 16'h0000, 0);
        tbl[1]  = mk(0, 1, 3'b111, 3'b000, A, D, 0,   3'b001, 3'b000, 0, 1, 0, 16'h0100, 16'h1111, 1);
        tbl[2]  = mk(0, 1, 3'b111, 3'b000, A, D, 0,   3'b001, 3'b000, 0, 1, 0, 16'h0100, 16'h1111, 1);
        tbl[3]  = mk(0, 1, 3'b111, 3'b000, A, D, 1,   3'b000, 3'b001, 0, 0, 0, 16'h0100, 16'h1111, 1);
        tbl[4]  = mk(0, 1, 3'b111, 3'b000, A, D, 0,   3'b000, 3'b000, 0, 0, 0, 16'h0100, 16'h1111, 0);
        tbl[5]  = mk(0, 1, 3'b111, 3'b000, A, D, 0,   3'b010, 3'b000, 0, 1, 0, 16'h0200, 16'h2222, 1);
        tbl[6]  = mk(0, 1, 3'b111, 3'b000, A, D, 0,   3'b010, 3'b000, 0, 1, 0, 16'h0200, 16'h2222, 1);
        tbl[7]  = mk(0, 1, 3'b111, 3'b000, A, D, 1,   3'b000, 3'b010, 0, 0, 0, 16'h0200, 16'h2222, 1);
        tbl[8]  = mk(0, 1, 3'b111, 3'b000, A, D, 0,   3'b000, 3'b000, 0, 0, 0, 16'h0200, 16'h2222, 0);
        tbl[9]  = mk(0, 1, 3'b111, 3'b000, A, D, 0,   3'b100, 3'b000, 0, 1, 0, 16'h0300, 16'h3333, 1);
        tbl[10] = mk(0, 1, 3'b111, 3'b000, A, D, 0,   3'b100, 3'b000, 0, 1, 0, 16'h0300, 16'h3333, 1);
        tbl[11] = mk(0, 1, 3'b111, 3'b000, A, D, 1,   3'b000, 3'b100, 0, 0, 0, 16'h0300, 16'h3333, 1);
        tbl[12] = mk(0, 1, 3'b111, 3'b000, A, D, 0,   3'b000, 3'b000, 0, 0, 0, 16'h0300, 16'h3333, 0);
        tbl[13] = mk(0, 1, 3'b111, 3'b000, A, D, 0,   3'b001, 3'b000, 0, 1, 0, 16'h0100, 16'h1111, 1);
        tbl[14] = mk(0, 1, 3'b111, 3'b000, A, D, 1,   3'b000, 3'b001, 0, 0, 0, 16'h0100, 16'h1111, 1);
        tbl[15] = mk(0, 1, 3'b000, 3'b000, A, D, 0,   3'b000, 3'b000, 0, 0, 0, 16'h0100, 16'h1111, 0);
        // enable low holds off requester 1 for five cycles
        tbl[16] = mk(0, 0, 3'b010, 3'b000, A, D, 0,   3'b000, 3'b000, 0, 0, 0, 16'h0100, 16'h1111, 0);
        tbl[17] = mk(0, 0, 3'b010, 3'b000, A, D, 0,   3'b000, 3'b000, 0, 0, 0, 16'h0100, 16'h1111, 0);
        tbl[18] = mk(0, 0, 3'b010, 3'b000, A, D, 0,   3'b000, 3'b000, 0, 0, 0, 16'h0100, 16'h1111, 0);
        tbl[19] = mk(0, 0, 3'b010, 3'b000, A, D, 0,   3'b000, 3'b000, 0, 0, 0, 16'h0100, 16'h1111, 0);
        tbl[20] = mk(0, 0, 3'b010, 3'b000, A, D, 0,   3'b000, 3'b000, 0, 0, 0, 16'h0100, 16'h1111, 0);
        tbl[21] = mk(0, 1, 3'b010, 3'b000, A, D, 0,   3'b010, 3'b000, 0, 1, 0, 16'h0200, 16'h2222, 1);
        // enable and req drop mid-access; access still completes, nothing new granted
        tbl[22] = mk(0, 0, 3'b000, 3'b000, AX, AX, 0, 3'b010, 3'b000, 0, 1, 0, 16'h0200, 16'h2222, 1);
        tbl[23] = mk(0, 0, 3'b000, 3'b000, A, D, 1,   3'b000, 3'b010, 0, 0, 0, 16'h0200, 16'h2222, 1);
        tbl[24] = mk(0, 0, 3'b111, 3'b000, A, D, 0,   3'b000, 3'b000, 0, 0, 0, 16'h0200, 16'h2222, 0);
        tbl[25] = mk(0, 0, 3'b111, 3'b000, A, D, 1,   3'b000, 3'b000, 0, 0, 0, 16'h0200, 16'h2222, 0);
        // write from requester 2; bus changes during BUSY are ignored
        tbl[26] = mk(0, 1, 3'b100, 3'b100, A38, D38, 0, 3'b100, 3'b000, 0, 1, 1, 16'h0040, 16'h1234, 1);
        tbl[27] = mk(0, 1, 3'b100, 3'b100, AX, AX, 0,   3'b100, 3'b000, 0, 1, 1, 16'h0040, 16'h1234, 1);
        tbl[28] = mk(0, 1, 3'b000, 3'b000, A, D, 1,     3'b000, 3'b100, 0, 0, 1, 16'h0040, 16'h1234, 1);
        tbl[29] = mk(0, 1, 3'b000, 3'b000, A, D, 0,     3'b000, 3'b000, 0, 0, 1, 16'h0040, 16'h1234, 0);

        drive(1, 0, 3'b000, 3'b000, A, D, 0);
        tick();
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].done);
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {22'd0, tbl[i].grant, tbl[i].rdone, tbl[i].err, tbl[i].dEn, tbl[i].dWr,
                   tbl[i].dAddr, tbl[i].dIn, tbl[i].busy});
        end

        // timeout: no dmaDone, reqDone+reqError after the 8th BUSY cycle
        drive(0, 1, 3'b001, 3'b000, A, D, 0);
        tick();
        check("to_grant", hs(), {56'd0, 3'b001, 3'b000, 1'b0, 1'b1});
        drive(0, 1, 3'b000, 3'b000, A, D, 0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("to_busy%0d", i), hs(), {56'd0, 3'b001, 3'b000, 1'b0, 1'b1});
        end
        tick();
        check("to_expire", hs(), {56'd0, 3'b000, 3'b001, 1'b1, 1'b1});
        tick();
        check("to_idle", hs(), {56'd0, 3'b000, 3'b000, 1'b0, 1'b0});

        // dmaDone coincident with the timeout wins, no reqError
        drive(0, 1, 3'b010, 3'b000, A, D, 0);
        tick();
        check("tie_grant", hs(), {56'd0, 3'b010, 3'b000, 1'b0, 1'b1});
        drive(0, 1, 3'b000, 3'b000, A, D, 0);
        for (int i = 1; i <= 7; i++) tick();
        check("tie_busy7", hs(), {56'd0, 3'b010, 3'b000, 1'b0, 1'b1});
        drive(0, 1, 3'b000, 3'b000, A, D, 1);
        tick();
        check("tie_done", hs(), {56'd0, 3'b000, 3'b010, 1'b0, 1'b1});
        drive(0, 1, 3'b000, 3'b000, A, D, 0);
        tick();
        check("tie_idle", hs(), {56'd0, 3'b000, 3'b000, 1'b0, 1'b0});

        // reset mid-BUSY abandons the access and restores requester-0 priority
        drive(0, 1, 3'b001, 3'b000, A, D, 0);
        tick();
        check("rst_grant", hs(), {56'd0, 3'b001, 3'b000, 1'b0, 1'b1});
        tick();
        drive(1, 1, 3'b001, 3'b000, A, D, 1);
        tick();
        check("rst_zero", outs(), 64'd0);
        drive(0, 1, 3'b011, 3'b000, A, D, 0);
        tick();
        check("rst_first", hs(), {56'd0, 3'b001, 3'b000, 1'b0, 1'b1});
        check("rst_addr", {48'd0, bus.dmaAddress}, 64'h0100);
        drive(0, 1, 3'b010, 3'b000, A, D, 1);
        tick();
        check("rst_done", hs(), {56'd0, 3'b000, 3'b001, 1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
